port_ring_tap_mc: RTL and testbench

PORT_RING_TAP_MC -- requirements
Module: port_ring_tap_mc

---
 rtl/ring_pkg.sv | 36 +++
 rtl/sat_counter.sv | 38 +++
 rtl/port_ring_tap_mc.sv | 195 +++++++++++++++++++
 tb/tb_port_ring_tap_mc.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/ring_pkg.sv
// Shared ring definitions: PCC codes, header-flag position and FSM state encoding.
package ring_pkg;

  // Packet control code, carried in the top two bits of a local data word.
  localparam logic [1:0] PccSop    = 2'b00;
  localparam logic [1:0] PccData   = 2'b01;
  localparam logic [1:0] PccEop    = 2'b10;
  localparam logic [1:0] PccBadeop = 2'b11;

  // One-hot state bit positions.
  localparam int unsigned IdxIdle  = 0;
  localparam int unsigned IdxTdata = 1;
  localparam int unsigned IdxTdrop = 2;
  localparam int unsigned IdxRfwd  = 3;
  localparam int unsigned IdxRcopy = 4;
  localparam int unsigned IdxRsink = 5;

  typedef enum logic [5:0] {
    StIdle  = 6'(1 << IdxIdle),
    StTdata = 6'(1 << IdxTdata),
    StTdrop = 6'(1 << IdxTdrop),
    StRfwd  = 6'(1 << IdxRfwd),
    StRcopy = 6'(1 << IdxRcopy),
    StRsink = 6'(1 << IdxRsink)
  } state_e;

  // The header flag is the MSB of a ring word.
  function automatic int unsigned hdr_bit(input int unsigned rdp_sz);
    return rdp_sz - 1;
  endfunction

  function automatic logic is_eop(input logic [1:0] pcc);
    return (pcc == PccEop) || (pcc == PccBadeop);
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear.
//   clk, reset : clock, asynchronous active-high reset
//   clr        : clear to zero (wins over inc)
//   inc        : increment by one, holding at MAX
//   count      : current value
module sat_counter #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned MAX   = 16'hFFFF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  logic [WIDTH-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (inc && (count_q != WIDTH'(MAX))) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/port_ring_tap_mc.sv
// Multicast ring tap: injects local packets onto the ring with a port-vector
// header, and forwards, copies or sinks ring packets addressed to this port.
//   lfli_*   : lookup result (destination vector), popped at packet start
//   lprx_*   : local receive stream (packets to inject)
//   lptx_*   : local transmit stream (ring packets for this port)
//   lri_*    : ring input;  lro_* : ring output
//   rarb_*   : ring arbiter request/grant for local injection
//   drop_cnt : saturating count of local packets dropped for a zero vector
module port_ring_tap_mc
  import ring_pkg::*;
#(
  parameter int unsigned NUM_PORTS  = 4,
  parameter int unsigned PDP_SZ     = 64,
  parameter int unsigned RDP_SZ     = 65,
  parameter int unsigned PORTNUM    = 0,
  parameter int unsigned STARVE_LIM = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 lfli_srdy,
  output logic                 lfli_drdy,
  input  logic [NUM_PORTS-1:0] lfli_data,
  input  logic                 lprx_srdy,
  output logic                 lprx_drdy,
  input  logic [PDP_SZ-1:0]    lprx_data,
  output logic                 lptx_srdy,
  input  logic                 lptx_drdy,
  output logic [PDP_SZ-1:0]    lptx_data,
  input  logic                 lri_srdy,
  output logic                 lri_drdy,
  input  logic [RDP_SZ-1:0]    lri_data,
  output logic                 lro_srdy,
  input  logic                 lro_drdy,
  output logic [RDP_SZ-1:0]    lro_data,
  output logic                 rarb_req,
  input  logic                 rarb_ack,
  output logic [15:0]          drop_cnt
);

  localparam int unsigned HdrBit  = hdr_bit(RDP_SZ);
  localparam int unsigned StarveW = $clog2(STARVE_LIM + 1);

  state_e state_q, state_d;

  logic [StarveW-1:0]   starve_cnt;
  logic                 ring_pri;
  logic                 local_start;
  logic                 hdr_accept;
  logic                 drop_inc;
  logic                 own_bit;
  logic [NUM_PORTS-1:0] rest_vec;
  logic [RDP_SZ-1:0]    local_hdr;
  logic [RDP_SZ-1:0]    copy_hdr;
  logic                 lprx_eop;
  logic                 lri_eop;

  assign ring_pri    = lri_srdy && (starve_cnt == StarveW'(STARVE_LIM));
  assign local_start = lfli_srdy && lprx_srdy && rarb_ack && !ring_pri;
  assign rarb_req    = !reset && ((lfli_srdy && lprx_srdy && !ring_pri) || (state_q == StTdata));

  assign own_bit   = lri_data[PORTNUM];
  assign rest_vec  = lri_data[NUM_PORTS-1:0] & ~(NUM_PORTS'(1) << PORTNUM);
  assign local_hdr = {1'b1, {(RDP_SZ - 1 - NUM_PORTS){1'b0}}, lfli_data};
  assign lprx_eop  = is_eop(lprx_data[PDP_SZ-1 -: 2]);
  assign lri_eop   = is_eop(lri_data[PDP_SZ-1 -: 2]);

  always_comb begin
    copy_hdr          = lri_data;
    copy_hdr[PORTNUM] = 1'b0;
  end

  always_comb begin
    state_d    = state_q;
    lfli_drdy  = 1'b0;
    lprx_drdy  = 1'b0;
    lptx_srdy  = 1'b0;
    lri_drdy   = 1'b0;
    lro_srdy   = 1'b0;
    lro_data   = lri_data;
    lptx_data  = lri_data[PDP_SZ-1:0];
    drop_inc   = 1'b0;
    hdr_accept = 1'b0;

    case (state_q)
      StIdle: begin
        if (local_start) begin
          if (|lfli_data) begin
            lro_srdy = 1'b1;
            lro_data = local_hdr;
            if (lro_drdy) begin
              lfli_drdy = 1'b1;
              state_d   = StTdata;
            end
          end else begin
            lfli_drdy = 1'b1;
            drop_inc  = 1'b1;
            state_d   = StTdrop;
          end
        end else if (lri_srdy) begin
          if (!lri_data[HdrBit]) begin
            // Stray data word with no header in front: discard it.
            lri_drdy = 1'b1;
          end else if (!own_bit) begin
            lro_srdy = 1'b1;
            if (lro_drdy) begin
              lri_drdy   = 1'b1;
              hdr_accept = 1'b1;
              state_d    = StRfwd;
            end
          end else if (|rest_vec) begin
            lro_srdy = 1'b1;
            lro_data = copy_hdr;
            if (lro_drdy) begin
              lri_drdy   = 1'b1;
              hdr_accept = 1'b1;
              state_d    = StRcopy;
            end
          end else begin
            lri_drdy   = 1'b1;
            hdr_accept = 1'b1;
            state_d    = StRsink;
          end
        end
      end
      StTdata: begin
        lro_srdy  = lprx_srdy;
        lro_data  = {1'b0, lprx_data};
        lprx_drdy = lro_drdy;
        if (lprx_srdy && lro_drdy && lprx_eop) state_d = StIdle;
      end
      StTdrop: begin
        lprx_drdy = 1'b1;
        if (lprx_srdy && lprx_eop) state_d = StIdle;
      end
      StRfwd: begin
        lro_srdy = lri_srdy;
        lri_drdy = lro_drdy;
        if (lri_srdy && lro_drdy && lri_eop) state_d = StIdle;
      end
      StRcopy: begin
        // Both sinks must be ready so the word is delivered to both at once.
        lro_srdy  = lri_srdy && lptx_drdy;
        lptx_srdy = lri_srdy && lro_drdy;
        lri_drdy  = lro_drdy && lptx_drdy;
        if (lri_srdy && lro_drdy && lptx_drdy && lri_eop) state_d = StIdle;
      end
      StRsink: begin
        lptx_srdy = lri_srdy;
        lri_drdy  = lptx_drdy;
        if (lri_srdy && lptx_drdy && lri_eop) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase

    // Handshakes are held low for as long as reset is asserted.
    if (reset) begin
      lfli_drdy = 1'b0;
      lprx_drdy = 1'b0;
      lptx_srdy = 1'b0;
      lri_drdy  = 1'b0;
      lro_srdy  = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  sat_counter #(
    .WIDTH (StarveW),
    .MAX   (STARVE_LIM)
  ) u_starve_cnt (
    .clk   (clk),
    .reset (reset),
    .clr   (hdr_accept || !lri_srdy),
    .inc   ((state_q == StIdle) && lri_srdy && !hdr_accept),
    .count (starve_cnt)
  );

  sat_counter #(
    .WIDTH (16),
    .MAX   (16'hFFFF)
  ) u_drop_cnt (
    .clk   (clk),
    .reset (reset),
    .clr   (1'b0),
    .inc   (drop_inc),
    .count (drop_cnt)
  );

endmodule

// File: tb/tb_port_ring_tap_mc.sv
module tb_port_ring_tap_mc;

  logic        clk = 1'b0;
  logic        reset;
  logic        lfli_srdy, lfli_drdy;
  logic [3:0]  lfli_data;
  logic        lprx_srdy, lprx_drdy;
  logic [63:0] lprx_data;
  logic        lptx_srdy, lptx_drdy;
  logic [63:0] lptx_data;
  logic        lri_srdy, lri_drdy;
  logic [64:0] lri_data;
  logic        lro_srdy, lro_drdy;
  logic [64:0] lro_data;
  logic        rarb_req, rarb_ack;
  logic [15:0] drop_cnt;

  int checks = 0;
  int errors = 0;

  localparam logic [5:0] SIdle  = 6'b000001;
  localparam logic [5:0] STdata = 6'b000010;
  localparam logic [5:0] STdrop = 6'b000100;
  localparam logic [5:0] SRfwd  = 6'b001000;
  localparam logic [5:0] SRcopy = 6'b010000;
  localparam logic [5:0] SRsink = 6'b100000;

  port_ring_tap_mc dut (
    .clk       (clk),
    .reset     (reset),
    .lfli_srdy (lfli_srdy),
    .lfli_drdy (lfli_drdy),
    .lfli_data (lfli_data),
    .lprx_srdy (lprx_srdy),
    .lprx_drdy (lprx_drdy),
    .lprx_data (lprx_data),
    .lptx_srdy (lptx_srdy),
    .lptx_drdy (lptx_drdy),
    .lptx_data (lptx_data),
    .lri_srdy  (lri_srdy),
    .lri_drdy  (lri_drdy),
    .lri_data  (lri_data),
    .lro_srdy  (lro_srdy),
    .lro_drdy  (lro_drdy),
    .lro_data  (lro_data),
    .rarb_req  (rarb_req),
    .rarb_ack  (rarb_ack),
    .drop_cnt  (drop_cnt)
  );

  always #5 clk = ~clk;

  function automatic logic [63:0] w(input logic [1:0] pcc, input logic [61:0] p);
    return {pcc, p};
  endfunction

  function automatic logic [64:0] hdr(input logic [3:0] v);
    return {1'b1, 60'd0, v};
  endfunction

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1;
    lfli_srdy = 0; lfli_data = 0; lprx_srdy = 0; lprx_data = 0;
    lptx_drdy = 1; lri_srdy = 0; lri_data = 0; lro_drdy = 1; rarb_ack = 0;
    step(); step();
    check("rst_state", 128'(dut.state_q), 128'(SIdle));
    check("rst_drop", 128'(drop_cnt), 128'(0));
    check("rst_lro_srdy", 128'(lro_srdy), 128'(0));
    check("rst_rarb_req", 128'(rarb_req), 128'(0));
    reset = 1'b0;

    // Local multicast, vector 0110, 3-word packet with one stall.
    lfli_srdy = 1; lfli_data = 4'b0110; lprx_srdy = 1; lprx_data = w(2'b00, 62'd1);
    rarb_ack = 1;
    #1;
    check("mc_rarb_req", 128'(rarb_req), 128'(1));
    check("mc_hdr_srdy", 128'(lro_srdy), 128'(1));
    check("mc_hdr_data", 128'(lro_data), 128'(hdr(4'b0110)));
    check("mc_lfli_pop", 128'(lfli_drdy), 128'(1));
    check("mc_lprx_hold", 128'(lprx_drdy), 128'(0));
    step();
    lfli_srdy = 0; lfli_data = 0;
    check("mc_st_tdata", 128'(dut.state_q), 128'(STdata));
    #1;
    check("mc_w0_data", 128'(lro_data), 128'({1'b0, w(2'b00, 62'd1)}));
    check("mc_w0_drdy", 128'(lprx_drdy), 128'(1));
    step();
    lprx_data = w(2'b01, 62'd2); lro_drdy = 0;
    #1;
    check("mc_stall_drdy", 128'(lprx_drdy), 128'(0));
    step();
    check("mc_stall_state", 128'(dut.state_q), 128'(STdata));
    lro_drdy = 1;
    #1;
    check("mc_w1_data", 128'(lro_data), 128'({1'b0, w(2'b01, 62'd2)}));
    step();
    lprx_data = w(2'b10, 62'd3);
    #1;
    check("mc_w2_data", 128'(lro_data), 128'({1'b0, w(2'b10, 62'd3)}));
    step();
    lprx_srdy = 0;
    check("mc_end_idle", 128'(dut.state_q), 128'(SIdle));

    // Zero-vector drop of a 5-word packet.
    lfli_srdy = 1; lfli_data = 4'b0000; lprx_srdy = 1; lprx_data = w(2'b00, 62'd0);
    #1;
    check("drop_lfli_pop", 128'(lfli_drdy), 128'(1));
    check("drop_lro_idle", 128'(lro_srdy), 128'(0));
    step();
    lfli_srdy = 0;
    check("drop_st_tdrop", 128'(dut.state_q), 128'(STdrop));
    check("drop_cnt_1", 128'(drop_cnt), 128'(1));
    for (int i = 0; i < 5; i++) begin
      lprx_data = w((i == 0) ? 2'b00 : (i == 4) ? 2'b10 : 2'b01, 62'(i));
      #1;
      check("drop_lprx_drdy", 128'(lprx_drdy), 128'(1));
      check("drop_lro_quiet", 128'(lro_srdy), 128'(0));
      step();
    end
    lprx_srdy = 0;
    check("drop_end_idle", 128'(dut.state_q), 128'(SIdle));
    check("drop_cnt_end", 128'(drop_cnt), 128'(1));

    // Ring copy: header 0011 at port 0.
    lri_srdy = 1; lri_data = hdr(4'b0011);
    #1;
    check("cp_hdr_srdy", 128'(lro_srdy), 128'(1));
    check("cp_hdr_data", 128'(lro_data), 128'(hdr(4'b0010)));
    check("cp_hdr_pop", 128'(lri_drdy), 128'(1));
    check("cp_hdr_no_lptx", 128'(lptx_srdy), 128'(0));
    step();
    check("cp_st_rcopy", 128'(dut.state_q), 128'(SRcopy));
    for (int i = 0; i < 3; i++) begin
      lri_data = {1'b0, w((i == 0) ? 2'b00 : (i == 2) ? 2'b10 : 2'b01, 62'(10 + i))};
      if (i == 1) begin
        lptx_drdy = 0;
        #1;
        check("cp_bp_lri_drdy", 128'(lri_drdy), 128'(0));
        check("cp_bp_lro_srdy", 128'(lro_srdy), 128'(0));
        step();
        lptx_drdy = 1;
      end
      #1;
      check("cp_lro_data", 128'(lro_data), 128'({1'b0, w((i == 0) ? 2'b00 :
            (i == 2) ? 2'b10 : 2'b01, 62'(10 + i))}));
      check("cp_lptx_data", 128'(lptx_data), 128'(w((i == 0) ? 2'b00 :
            (i == 2) ? 2'b10 : 2'b01, 62'(10 + i))));
      check("cp_lptx_srdy", 128'(lptx_srdy), 128'(1));
      check("cp_lri_drdy", 128'(lri_drdy), 128'(1));
      step();
    end
    check("cp_end_idle", 128'(dut.state_q), 128'(SIdle));

    // Ring sink: header 0001 at port 0.
    lri_data = hdr(4'b0001);
    #1;
    check("sk_hdr_no_lro", 128'(lro_srdy), 128'(0));
    check("sk_hdr_pop", 128'(lri_drdy), 128'(1));
    step();
    check("sk_st_rsink", 128'(dut.state_q), 128'(SRsink));
    for (int i = 0; i < 2; i++) begin
      lri_data = {1'b0, w((i == 0) ? 2'b00 : 2'b10, 62'(20 + i))};
      #1;
      check("sk_lptx_srdy", 128'(lptx_srdy), 128'(1));
      check("sk_lptx_data", 128'(lptx_data), 128'(w((i == 0) ? 2'b00 : 2'b10, 62'(20 + i))));
      check("sk_lro_quiet", 128'(lro_srdy), 128'(0));
      step();
    end
    check("sk_end_idle", 128'(dut.state_q), 128'(SIdle));

    // Starvation: local 1-word packets back-to-back while a ring header waits.
    lri_data = hdr(4'b0100);
    lfli_srdy = 1; lfli_data = 4'b0010; lprx_srdy = 1; lprx_data = w(2'b10, 62'd5);
    for (int k = 0; k < 8; k++) begin
      #1;
      check("sv_local_wins", 128'(lfli_drdy), 128'(1));
      check("sv_ring_waits", 128'(lri_drdy), 128'(0));
      step();
      step();
    end
    #1;
    check("sv_ring_pop", 128'(lri_drdy), 128'(1));
    check("sv_rarb_req_0", 128'(rarb_req), 128'(0));
    check("sv_lfli_held", 128'(lfli_drdy), 128'(0));
    check("sv_hdr_fwd", 128'(lro_data), 128'(hdr(4'b0100)));
    step();
    check("sv_st_rfwd", 128'(dut.state_q), 128'(SRfwd));
    check("sv_starve_clr", 128'(dut.starve_cnt), 128'(0));
    lfli_srdy = 0; lprx_srdy = 0;
    lri_data = {1'b0, w(2'b10, 62'd6)};
    #1;
    check("sv_fwd_data", 128'(lro_data), 128'({1'b0, w(2'b10, 62'd6)}));
    step();
    check("sv_end_idle", 128'(dut.state_q), 128'(SIdle));

    // Ring proceeds while arbiter withholds grant; then reset mid-RCOPY.
    lri_data = hdr(4'b0011);
    lfli_srdy = 1; lfli_data = 4'b0100; lprx_srdy = 1; lprx_data = w(2'b00, 62'd7);
    rarb_ack = 0;
    #1;
    check("na_rarb_req", 128'(rarb_req), 128'(1));
    check("na_ring_pop", 128'(lri_drdy), 128'(1));
    check("na_lfli_held", 128'(lfli_drdy), 128'(0));
    step();
    check("rr_st_rcopy", 128'(dut.state_q), 128'(SRcopy));
    lri_data = {1'b0, w(2'b00, 62'd8)};
    step();
    lri_data = {1'b0, w(2'b01, 62'd9)};
    #1;
    check("rr_w2_live", 128'(lri_drdy), 128'(1));
    reset = 1'b1;
    #1;
    check("rr_lro_srdy", 128'(lro_srdy), 128'(0));
    check("rr_lptx_srdy", 128'(lptx_srdy), 128'(0));
    check("rr_lri_drdy", 128'(lri_drdy), 128'(0));
    check("rr_lfli_drdy", 128'(lfli_drdy), 128'(0));
    check("rr_rarb_req", 128'(rarb_req), 128'(0));
    check("rr_state", 128'(dut.state_q), 128'(SIdle));
    check("rr_drop", 128'(drop_cnt), 128'(0));
    check("rr_starve", 128'(dut.starve_cnt), 128'(0));
    lfli_srdy = 0; lprx_srdy = 0; lri_srdy = 0;
    step();
    reset = 1'b0;
    step();
    check("rr_post_idle", 128'(dut.state_q), 128'(SIdle));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
